ants_master_lock_reset_seq: RTL and testbench

Fabric-side consumer of the MSS CCC lock and clock outputs. Runs on the CCC-generated fabric clock, synchronizes and qualifies the CCC lock indication, and releases a staged set of active-high fabric resets once lock has been stable. It re-asserts all resets on lock loss or a software request. It sits directly after the CCC wrapper and feeds reset to every fabric block in the ANTS master.

---
 rtl/ants_master_rst_pkg.sv | 25 ++
 rtl/ants_master_sync_bit.sv | 23 ++
 rtl/ants_master_lock_reset_seq.sv | 159 +++++++++++++++
 tb/tb_ants_master_lock_reset_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ants_master_rst_pkg.sv
// Shared types and constants for the ANTS master lock-qualified reset sequencer.
// Build option ANTS_LOCK_BYPASS_EN is consumed by ants_master_lock_reset_seq.
package ants_master_rst_pkg;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABLE    = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    typedef enum logic [1:0] {
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        RELEASE   = ST_RELEASE,
        RUN       = ST_RUN
    } rst_state_e;

    localparam int LOSS_COUNT_W = 8;
    localparam logic [LOSS_COUNT_W-1:0] LOSS_COUNT_MAX = 8'd255;

    // Saturating increment for the lock-loss event counter.
    function automatic logic [LOSS_COUNT_W-1:0] loss_sat_inc(input logic [LOSS_COUNT_W-1:0] v);
        return (v == LOSS_COUNT_MAX) ? v : v + LOSS_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/ants_master_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; synchronous reset to 0.
module ants_master_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ants_master_lock_reset_seq.sv
// Qualifies the CCC lock on FAB_CLK and releases staged fabric resets once lock is stable.
// Define ANTS_LOCK_BYPASS_EN for CCC-bypass builds: lock is then treated as always present.
module ants_master_lock_reset_seq
    import ants_master_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_STAGES       = 3,
    parameter int STAGE_GAP          = 16
) (
    input  logic                    FAB_CLK,
    input  logic                    FAB_RESET,
    input  logic                    LOCK_IN,
    input  logic                    SOFT_RST_REQ,
    output logic [RESET_STAGES-1:0] RST_OUT,
    output logic                    READY,
    output logic                    LOCK_LOST,
    output logic [LOSS_COUNT_W-1:0] LOSS_COUNT
);

    localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GAP_W  = $clog2(RESET_STAGES * STAGE_GAP + 1);
    localparam logic [STAB_W-1:0] STAB_TARGET = STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [GAP_W-1:0]  LAST_GAP    = GAP_W'((RESET_STAGES - 1) * STAGE_GAP);

    logic lock_s;

`ifdef ANTS_LOCK_BYPASS_EN
    localparam bit LOSS_EN = 1'b0;
    logic unused_lock_in;
    assign unused_lock_in = LOCK_IN;
    assign lock_s = 1'b1;
`else
    localparam bit LOSS_EN = 1'b1;
    ants_master_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (FAB_CLK),
        .rst_i (FAB_RESET),
        .d_i   (LOCK_IN),
        .q_o   (lock_s)
    );
`endif

    rst_state_e              state_q, state_d;
    logic                    lock_q;
    logic [STAB_W-1:0]       stab_q, stab_d;
    logic [GAP_W-1:0]        gap_q, gap_d, gap_next;
    logic [RESET_STAGES-1:0] rst_q, rst_d;
    logic                    ready_q, ready_d;
    logic                    lost_q, lost_d;
    logic [LOSS_COUNT_W-1:0] loss_q, loss_d;
    logic                    restart;

    assign gap_next = gap_q + GAP_W'(1);

    // Only a sequence that has started releasing counts as a lock loss.
    assign restart = ((state_q == RELEASE) || (state_q == RUN)) && (!lock_q || SOFT_RST_REQ);

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        gap_d   = gap_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        lost_d  = 1'b0;
        loss_d  = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                rst_d   = '1;
                ready_d = 1'b0;
                stab_d  = '0;
                gap_d   = '0;
                if (lock_q) begin
                    state_d = STABLE;
                    stab_d  = STAB_W'(1);
                end
            end
            STABLE: begin
                if (!lock_q || SOFT_RST_REQ) begin
                    state_d = WAIT_LOCK;
                    stab_d  = '0;
                end else if (stab_q == STAB_TARGET) begin
                    state_d  = RELEASE;
                    gap_d    = '0;
                    rst_d[0] = 1'b0;
                    if (RESET_STAGES == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            RELEASE: begin
                gap_d = gap_next;
                for (int i = 1; i < RESET_STAGES; i++) begin
                    if (gap_next == GAP_W'(i * STAGE_GAP)) begin
                        rst_d[i] = 1'b0;
                    end
                end
                if (gap_next == LAST_GAP) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = WAIT_LOCK;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase

        // Any re-assertion restarts the whole sequence; loss takes priority over soft request.
        if (restart) begin
            state_d = WAIT_LOCK;
            rst_d   = '1;
            ready_d = 1'b0;
            stab_d  = '0;
            gap_d   = '0;
            if (!lock_q && LOSS_EN) begin
                lost_d = 1'b1;
                loss_d = loss_sat_inc(loss_q);
            end
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            state_q <= WAIT_LOCK;
            lock_q  <= 1'b0;
            stab_q  <= '0;
            gap_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_s;
            stab_q  <= stab_d;
            gap_q   <= gap_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
            loss_q  <= loss_d;
        end
    end

    assign RST_OUT    = rst_q;
    assign READY      = ready_q;
    assign LOCK_LOST  = lost_q;
    assign LOSS_COUNT = loss_q;

endmodule

// File: tb/tb_ants_master_lock_reset_seq.sv
// Directed bench for ants_master_lock_reset_seq with SYNC_STAGES=2, LOCK_STABLE_CYCLES=8,
// RESET_STAGES=3, STAGE_GAP=4; a bypass build (ANTS_LOCK_BYPASS_EN) runs its own short sequence.
module tb_ants_master_lock_reset_seq;

    localparam int S = 2;
    localparam int L = 8;
    localparam int R = 3;
    localparam int G = 4;

    logic         FAB_CLK = 1'b0;
    logic         FAB_RESET;
    logic         LOCK_IN;
    logic         SOFT_RST_REQ;
    logic [R-1:0] RST_OUT;
    logic         READY;
    logic         LOCK_LOST;
    logic [7:0]   LOSS_COUNT;

    int checks = 0;
    int errors = 0;
    int lost_pulses = 0;

    always #5 FAB_CLK = ~FAB_CLK;

    ants_master_lock_reset_seq #(
        .SYNC_STAGES        (S),
        .LOCK_STABLE_CYCLES (L),
        .RESET_STAGES       (R),
        .STAGE_GAP          (G)
    ) dut (
        .FAB_CLK      (FAB_CLK),
        .FAB_RESET    (FAB_RESET),
        .LOCK_IN      (LOCK_IN),
        .SOFT_RST_REQ (SOFT_RST_REQ),
        .RST_OUT      (RST_OUT),
        .READY        (READY),
        .LOCK_LOST    (LOCK_LOST),
        .LOSS_COUNT   (LOSS_COUNT)
    );

    always @(negedge FAB_CLK) begin
        if (LOCK_LOST === 1'b1) lost_pulses++;
    end

    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_out"}, 32'(RST_OUT), 32'h7);
        chk({tag, "_ready"}, 32'(READY), 32'h0);
        chk({tag, "_lock_lost"}, 32'(LOCK_LOST), 32'h0);
        chk({tag, "_loss_count"}, 32'(LOSS_COUNT), 32'h0);
    endtask

    // Called right after LOCK_IN goes high; the next edge is edge 0.
    task automatic lock_seq(input string tag);
        repeat (11) tick();
        chk({tag, "_e10_rst"}, 32'(RST_OUT), 32'h7);
        tick();
        chk({tag, "_e11_rst"}, 32'(RST_OUT), 32'h6);
        chk({tag, "_e11_ready"}, 32'(READY), 32'h0);
        repeat (3) tick();
        chk({tag, "_e14_rst"}, 32'(RST_OUT), 32'h6);
        tick();
        chk({tag, "_e15_rst"}, 32'(RST_OUT), 32'h4);
        repeat (3) tick();
        chk({tag, "_e18_rst"}, 32'(RST_OUT), 32'h4);
        chk({tag, "_e18_ready"}, 32'(READY), 32'h0);
        tick();
        chk({tag, "_e19_rst"}, 32'(RST_OUT), 32'h0);
        chk({tag, "_e19_ready"}, 32'(READY), 32'h1);
    endtask

    initial begin
        FAB_RESET    = 1'b1;
        LOCK_IN      = 1'b0;
        SOFT_RST_REQ = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");

`ifdef ANTS_LOCK_BYPASS_EN
        FAB_RESET = 1'b0;
        tick();
        repeat (8) tick();
        chk("byp_e8_rst", 32'(RST_OUT), 32'h7);
        tick();
        chk("byp_e9_rst", 32'(RST_OUT), 32'h6);
        repeat (8) tick();
        chk("byp_run_rst", 32'(RST_OUT), 32'h0);
        chk("byp_run_ready", 32'(READY), 32'h1);
        SOFT_RST_REQ = 1'b1;
        tick();
        SOFT_RST_REQ = 1'b0;
        chk("byp_soft_rst", 32'(RST_OUT), 32'h7);
        chk("byp_soft_ready", 32'(READY), 32'h0);
        repeat (8) tick();
        chk("byp_soft_e8_rst", 32'(RST_OUT), 32'h7);
        tick();
        chk("byp_soft_e9_rst", 32'(RST_OUT), 32'h6);
        chk("byp_lost", 32'(lost_pulses), 32'h0);
        chk("byp_loss_count", 32'(LOSS_COUNT), 32'h0);
`else
        FAB_RESET = 1'b0;
        tick();
        chk("wait_no_lock_rst", 32'(RST_OUT), 32'h7);

        // Clean lock.
        LOCK_IN = 1'b1;
        lock_seq("clean");
        chk("clean_no_lost", 32'(lost_pulses), 32'h0);

        // Lock loss in RUN: outputs react at k+3.
        LOCK_IN = 1'b0;
        repeat (2) tick();
        chk("loss_k1_rst", 32'(RST_OUT), 32'h0);
        tick();
        chk("loss_k2_rst", 32'(RST_OUT), 32'h0);
        chk("loss_k2_ready", 32'(READY), 32'h1);
        tick();
        chk("loss_k3_rst", 32'(RST_OUT), 32'h7);
        chk("loss_k3_ready", 32'(READY), 32'h0);
        chk("loss_k3_lost", 32'(LOCK_LOST), 32'h1);
        chk("loss_k3_count", 32'(LOSS_COUNT), 32'h1);
        tick();
        chk("loss_k4_lost", 32'(LOCK_LOST), 32'h0);
        chk("loss_pulses", 32'(lost_pulses), 32'h1);
        LOCK_IN = 1'b1;
        lock_seq("relock");

        // Soft reset alone in RUN.
        SOFT_RST_REQ = 1'b1;
        tick();
        SOFT_RST_REQ = 1'b0;
        chk("soft_rst", 32'(RST_OUT), 32'h7);
        chk("soft_ready", 32'(READY), 32'h0);
        chk("soft_lost", 32'(LOCK_LOST), 32'h0);
        chk("soft_count", 32'(LOSS_COUNT), 32'h1);
        repeat (8) tick();
        chk("soft_e8_rst", 32'(RST_OUT), 32'h7);
        tick();
        chk("soft_e9_rst", 32'(RST_OUT), 32'h6);
        repeat (8) tick();
        chk("soft_run_rst", 32'(RST_OUT), 32'h0);
        chk("soft_run_ready", 32'(READY), 32'h1);

        // Soft reset in the same cycle the qualified lock falls: loss wins.
        LOCK_IN = 1'b0;
        repeat (3) tick();
        SOFT_RST_REQ = 1'b1;
        tick();
        SOFT_RST_REQ = 1'b0;
        chk("collide_rst", 32'(RST_OUT), 32'h7);
        chk("collide_ready", 32'(READY), 32'h0);
        chk("collide_lost", 32'(LOCK_LOST), 32'h1);
        chk("collide_count", 32'(LOSS_COUNT), 32'h2);

        // Unstable lock: high 5, low 1, high; release 11 edges after the final rise.
        repeat (4) tick();
        LOCK_IN = 1'b1;
        repeat (5) tick();
        LOCK_IN = 1'b0;
        tick();
        LOCK_IN = 1'b1;
        repeat (11) tick();
        chk("unstable_e16_rst", 32'(RST_OUT), 32'h7);
        tick();
        chk("unstable_e17_rst", 32'(RST_OUT), 32'h6);
        chk("unstable_count", 32'(LOSS_COUNT), 32'h2);
        chk("unstable_pulses", 32'(lost_pulses), 32'h2);
        repeat (8) tick();
        chk("unstable_run_rst", 32'(RST_OUT), 32'h0);
        chk("unstable_run_ready", 32'(READY), 32'h1);

        // Saturation: 260 loss/relock cycles, each loss landing after release has begun.
        for (int i = 0; i < 260; i++) begin
            LOCK_IN = 1'b0;
            repeat (4) tick();
            chk("sat_count", 32'(LOSS_COUNT), (i + 3 > 255) ? 32'd255 : 32'(i + 3));
            LOCK_IN = 1'b1;
            repeat (12) tick();
        end
        chk("sat_release_rst", 32'(RST_OUT), 32'h6);

        // FAB_RESET while releasing.
        repeat (4) tick();
        chk("midrel_rst", 32'(RST_OUT), 32'h4);
        FAB_RESET = 1'b1;
        tick();
        chk_reset_vals("midrel_reset");
        FAB_RESET = 1'b0;
        lock_seq("post_reset");
        chk("post_reset_count", 32'(LOSS_COUNT), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
